ui_stroke_plotter: RTL and testbench
====================================

UI_STROKE_PLOTTER -- requirements
Module: ui_stroke_plotter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter X_W, 8, x coordinate width.
REQ-003 Parameter Y_W, 7, y coordinate width.
REQ-004 Parameter ORIGIN_X, 79, x of the glyph vertex.
REQ-005 Parameter ORIGIN_Y, 63, y of the glyph vertex.
REQ-006 Parameter LEN_A, 5, stroke A pixel count (>=1).
REQ-007 Parameter LEN_B, 8, stroke B pixel count (>=1).
REQ-008 Parameter STEP_CYCLES, 4, clocks per plotted pixel (>=1).
REQ-009 Parameter HOLD_CYCLES, 10, clocks between the last pixel and done (>=0).
REQ-010 Parameter COLOUR, 3'b010, draw colour.
REQ-011 clk  in  1  system clock; all state changes on its rising edge.
REQ-012 reset  in  1  synchronous active-high reset.
REQ-013 start  in  1  level-sampled request to draw; accepted only in IDLE.
REQ-014 erase  in  1  sampled with an accepted start; 1 = draw in colour 3'b000.
REQ-015 x  out  X_W  pixel x, valid while plot=1.
REQ-016 y  out  Y_W  pixel y, valid while plot=1.
REQ-017 colour  out  3  pixel colour, valid while plot=1.
REQ-018 plot  out  1  one-cycle write strobe per pixel.
REQ-019 busy  out  1  high from acceptance through the end of HOLD.
REQ-020 done  out  1  one-cycle completion pulse.

Function
REQ-021 The FSM SHALL have states IDLE, STROKE_A, STROKE_B, HOLD, DONE; all outputs SHALL be registered.
REQ-022 IDLE -> STROKE_A when start=1 at a clock edge; erase SHALL be latched at that edge; the step divider and pixel index SHALL clear.
REQ-023 Cycle 1 is the cycle after the accepting edge; the k-th pixel (k=1..LEN_A+LEN_B) SHALL have plot=1 in cycle k*STEP_CYCLES only.
REQ-024 Stroke A pixel i (i=0..LEN_A-1): x=ORIGIN_X-i, y=ORIGIN_Y-i.
REQ-025 Stroke B pixel j (j=1..LEN_B): x=ORIGIN_X+j, y=ORIGIN_Y-j; STROKE_A -> STROKE_B after the last stroke A pixel.
REQ-026 colour SHALL be 3'b000 if latched erase=1, else COLOUR, for every pixel of the run.
REQ-027 Coordinate arithmetic SHALL be modulo 2^X_W / 2^Y_W; out-of-range parameter choices wrap, with no saturation and no error flag.
REQ-028 After the last stroke B pixel, HOLD SHALL last HOLD_CYCLES clocks; busy SHALL be high in cycles 1 .. (LEN_A+LEN_B)*STEP_CYCLES+HOLD_CYCLES.
REQ-029 DONE SHALL last exactly one cycle, with done=1 and busy=0, then return to IDLE.
REQ-030 start SHALL be ignored in every state except IDLE; erase changes after acceptance SHALL have no effect.
REQ-031 start held high continuously SHALL re-trigger a run in the cycle after DONE (IDLE accepts it at the next edge).
REQ-032 Between plot pulses, x and y SHALL hold the last plotted values; plot SHALL never be high in IDLE, HOLD or DONE.

Reset
REQ-033 reset=1 at an edge SHALL force IDLE regardless of state, discard the latched erase, and clear the divider and index.
REQ-034 Reset values: x=ORIGIN_X, y=ORIGIN_Y, colour=3'b000, plot=0, busy=0, done=0.
REQ-035 reset SHALL take priority over a simultaneous start.
REQ-036 Reset mid-run SHALL suppress all remaining plot pulses and SHALL produce no done pulse.

Verification
REQ-037 Defaults, erase=0, single-cycle start -> plot in cycles 4,8,..,52 (13 pulses) at (79,63),(78,62),(77,61),(76,60),(75,59),(80,62),..,(87,55); colour=3'b010 on each pulse.
REQ-038 Same run -> busy high in cycles 1..62, done=1 and busy=0 in cycle 63, IDLE in cycle 64.
REQ-039 erase=1 with start, then erase=0 in cycle 2 -> same 13 coordinates, colour=3'b000 on all pulses.
REQ-040 start pulsed again in cycles 10 and 40 -> no effect; exactly 13 plots and 1 done.
REQ-041 reset=1 in cycle 30 -> outputs at reset values from cycle 31; no further plot pulses; no done pulse.
REQ-042 STEP_CYCLES=1, HOLD_CYCLES=0, ORIGIN_X=2 -> plot in cycles 1..13; stroke A x values 2,1,0,255,254; done in cycle 14.

Source files
------------

// File: rtl/ui_stroke_plotter.sv
// Two-stroke "V" glyph plotter.
// Emits one pixel write strobe every STEP_CYCLES clocks, then holds and pulses done.
module ui_stroke_plotter #(
    parameter int          X_W         = 8,
    parameter int          Y_W         = 7,
    parameter int          ORIGIN_X    = 79,
    parameter int          ORIGIN_Y    = 63,
    parameter int          LEN_A       = 5,
    parameter int          LEN_B       = 8,
    parameter int          STEP_CYCLES = 4,
    parameter int          HOLD_CYCLES = 10,
    parameter logic [2:0]  COLOUR      = 3'b010
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           erase,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [2:0]     colour,
    output logic           plot,
    output logic           busy,
    output logic           done
);

    localparam int N  = LEN_A + LEN_B;
    localparam int DW = $clog2(STEP_CYCLES + 1);
    localparam int IW = $clog2(N + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 2);

    localparam logic [X_W-1:0] OX = X_W'(ORIGIN_X);
    localparam logic [Y_W-1:0] OY = Y_W'(ORIGIN_Y);
    localparam logic [DW-1:0]  DIV_LAST  = DW'(STEP_CYCLES - 1);
    localparam logic [IW-1:0]  IDX_LAST  = IW'(N - 1);
    localparam logic [IW-1:0]  IDX_B     = IW'(LEN_A);
    localparam logic [HW-1:0]  HOLD_LAST =
        HW'(HOLD_CYCLES > 0 ? HOLD_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        STROKE_A,
        STROKE_B,
        HOLD,
        DONE
    } state_t;

    state_t         state, state_n;
    logic [DW-1:0]  div, div_n;
    logic [IW-1:0]  idx, idx_n;
    logic [HW-1:0]  hcnt, hcnt_n;
    logic           erase_q, erase_n;
    logic           emit;
    logic           busy_n;
    logic [IW-1:0]  j;
    logic [X_W-1:0] px;
    logic [Y_W-1:0] py;

    always_comb begin
        state_n = state;
        div_n   = div;
        idx_n   = idx;
        hcnt_n  = hcnt;
        erase_n = erase_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = STROKE_A;
                    erase_n = erase;
                    div_n   = '0;
                    idx_n   = '0;
                end
            end
            STROKE_A, STROKE_B: begin
                if (div == DIV_LAST) begin
                    div_n = '0;
                    idx_n = idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        idx_n  = idx;
                        hcnt_n = '0;
                        if (HOLD_CYCLES > 0) state_n = HOLD;
                        else                 state_n = DONE;
                    end else if (idx_n == IDX_B) begin
                        state_n = STROKE_B;
                    end
                end else begin
                    div_n = div + 1'b1;
                end
            end
            HOLD: begin
                if (hcnt == HOLD_LAST) state_n = DONE;
                else                   hcnt_n  = hcnt + 1'b1;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered, so the pixel is decided one edge ahead.
    assign emit = (state_n == STROKE_A || state_n == STROKE_B)
               && (div_n == DIV_LAST);
    assign busy_n = (state_n == STROKE_A) || (state_n == STROKE_B)
                 || (state_n == HOLD);

    always_comb begin
        j  = '0;
        px = OX - X_W'(idx_n);
        py = OY - Y_W'(idx_n);
        if (idx_n >= IDX_B) begin
            j  = idx_n - IDX_B + 1'b1;
            px = OX + X_W'(j);
            py = OY - Y_W'(j);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            div     <= '0;
            idx     <= '0;
            hcnt    <= '0;
            erase_q <= 1'b0;
        end else begin
            state   <= state_n;
            div     <= div_n;
            idx     <= idx_n;
            hcnt    <= hcnt_n;
            erase_q <= erase_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x      <= OX;
            y      <= OY;
            colour <= 3'b000;
            plot   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            plot <= emit;
            busy <= busy_n;
            done <= (state_n == DONE);
            if (emit) begin
                x      <= px;
                y      <= py;
                colour <= erase_n ? 3'b000 : COLOUR;
            end
        end
    end

endmodule

// File: tb/tb_ui_stroke_plotter.sv
// Directed bench for ui_stroke_plotter: default glyph, erase, ignored starts,
// mid-run reset, re-trigger, and a fast variant with x wrap-around.
module tb_ui_stroke_plotter;

    logic       clk = 1'b0;
    logic       reset, start, erase, start_f;
    logic [7:0] x, fx;
    logic [6:0] y, fy;
    logic [2:0] colour, fcol;
    logic       plot, busy, done;
    logic       fplot, fbusy, fdone;

    int checks = 0;
    int errors = 0;
    int lx, ly, lc;

    int ex[13]  = '{79, 78, 77, 76, 75, 80, 81, 82, 83, 84, 85, 86, 87};
    int ey[13]  = '{63, 62, 61, 60, 59, 62, 61, 60, 59, 58, 57, 56, 55};
    int fxe[13] = '{2, 1, 0, 255, 254, 3, 4, 5, 6, 7, 8, 9, 10};

    always #5 clk = ~clk;

    ui_stroke_plotter dut (
        .clk(clk), .reset(reset), .start(start), .erase(erase),
        .x(x), .y(y), .colour(colour),
        .plot(plot), .busy(busy), .done(done)
    );

    ui_stroke_plotter #(
        .STEP_CYCLES(1), .HOLD_CYCLES(0), .ORIGIN_X(2)
    ) dut_f (
        .clk(clk), .reset(reset), .start(start_f), .erase(erase),
        .x(fx), .y(fy), .colour(fcol),
        .plot(fplot), .busy(fbusy), .done(fdone)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic run(input bit er, input bit pulses,
                       input int rst_at, input bit hold);
        int  nplot, ndone, eplot, edone, k;
        bit  ep, eb, ed;
        nplot = 0; ndone = 0; eplot = 0; edone = 0;
        @(negedge clk);
        start = 1'b1;
        erase = er;
        for (int c = 1; c <= 66; c++) begin
            @(negedge clk);
            if (rst_at > 0 && c > rst_at) begin
                ep = 0; eb = 0; ed = 0;
                lx = 79; ly = 63; lc = 0;
            end else begin
                ep = (c % 4 == 0) && (c <= 52);
                eb = (c <= 62) || (hold && c >= 65);
                ed = (c == 63);
                if (ep) begin
                    k  = c / 4 - 1;
                    lx = ex[k];
                    ly = ey[k];
                    lc = er ? 0 : 2;
                end
            end
            eplot += int'(ep);
            edone += int'(ed);
            chk($sformatf("plot c%0d", c), plot, ep);
            chk($sformatf("busy c%0d", c), busy, eb);
            chk($sformatf("done c%0d", c), done, ed);
            chk($sformatf("x c%0d", c), x, lx);
            chk($sformatf("y c%0d", c), y, ly);
            chk($sformatf("colour c%0d", c), colour, lc);
            nplot += int'(plot);
            ndone += int'(done);
            start = hold || (pulses && (c == 10 || c == 40));
            if (c == 2) erase = 1'b0;
            reset = (rst_at == c);
        end
        if (!hold) begin
            chk("plot count", nplot, eplot);
            chk("done count", ndone, edone);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; erase = 1'b0; start_f = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst x", x, 79);
        chk("rst y", y, 63);
        chk("rst colour", colour, 0);
        chk("rst plot", plot, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst fx", fx, 2);
        chk("rst fbusy", fbusy, 0);
        lx = 79; ly = 63; lc = 0;

        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("prio busy", busy, 0);
        chk("prio plot", plot, 0);

        run(1'b0, 1'b0, 0, 1'b0);
        run(1'b1, 1'b0, 0, 1'b0);
        run(1'b0, 1'b1, 0, 1'b0);
        run(1'b0, 1'b0, 30, 1'b0);
        run(1'b0, 1'b0, 0, 1'b1);

        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("post rst busy", busy, 0);
        chk("post rst x", x, 79);

        @(negedge clk);
        start_f = 1'b1;
        lx = 2; ly = 63; lc = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            start_f = 1'b0;
            if (c <= 13) begin
                lx = fxe[c-1];
                ly = ey[c-1];
                lc = 2;
            end
            chk($sformatf("f plot c%0d", c), fplot, int'(c <= 13));
            chk($sformatf("f busy c%0d", c), fbusy, int'(c <= 13));
            chk($sformatf("f done c%0d", c), fdone, int'(c == 14));
            chk($sformatf("f x c%0d", c), fx, lx);
            chk($sformatf("f y c%0d", c), fy, ly);
            chk($sformatf("f colour c%0d", c), fcol, lc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
